// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and the IF/ID pipeline register.
// No logic of its own: state encoding, word geometry and the IF/ID payload struct.
// Imported by every file of the fetch slice.
package fetch_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int ADDR_W      = 64;
    localparam int INSTR_W     = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } ifid_reg_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-ROM bus: byte address out, instruction word back in the same cycle.
// Latency 0 (combinational ROM); no backpressure, the ROM always answers.
// Master is the fetch stage, slave is the ROM.
interface fetch_stage_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0]  imem_address;
    logic [INSTR_W-1:0] imem_instruction;

    modport master (output imem_address, input imem_instruction);
    modport slave  (input imem_address, output imem_instruction);

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads d each edge unless held or flushed.
// Latency 1 clock; hold freezes the whole entry, flush clears only valid.
// Flush wins over hold so a squash is never lost behind a stall.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      hold,
    input  logic      flush,
    input  ifid_reg_t d,
    output ifid_reg_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (flush) begin
            q.valid <= 1'b0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, addresses the ROM and fills IF/ID. Optional FETCH_ALIGN_CHECK_EN.
// Latency: instruction reaches IF/ID one edge after its PC; redirect to first valid target is 2 edges.
// Backpressure: stall holds PC and IF/ID; redirect overrides stall; HALT is left only by reset.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC   = 64'd0,
    parameter int unsigned       IMEM_BYTES = 1024
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_target,
    fetch_stage_if.master       imem,
    output logic [ADDR_W-1:0]   ifid_pc,
    output logic [INSTR_W-1:0]  ifid_instr,
    output logic                ifid_valid,
    output logic                halted,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic                misalign_fault,
`endif
    output logic [31:0]         fetch_count
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(IMEM_BYTES);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W:0]   pc_plus4;
    logic [ADDR_W:0]   tgt_last_byte;
    logic              seq_end;
    logic              tgt_oob;
    logic              ifid_hold;
    logic              ifid_flush;
    logic              count_inc;
    ifid_reg_t         ifid_d;
    ifid_reg_t         ifid_q;

`ifdef FETCH_ALIGN_CHECK_EN
    logic              tgt_misaligned;
    logic              fault_set;
    logic              fault_q;

    assign tgt            = redirect_target;
    assign tgt_misaligned = |redirect_target[1:0];
`else
    assign tgt = {redirect_target[ADDR_W-1:2], 2'b00};
`endif

    // Widened by one bit so a PC or target near 2^64 cannot wrap past the limit check.
    assign pc_plus4      = {1'b0, pc_q} + (ADDR_W+1)'(INSTR_BYTES);
    assign tgt_last_byte = {1'b0, tgt} + (ADDR_W+1)'(INSTR_BYTES - 1);
    assign seq_end       = (pc_plus4 >= MEM_LIMIT);
    assign tgt_oob       = (tgt_last_byte >= MEM_LIMIT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ifid_hold  = 1'b0;
        ifid_flush = 1'b0;
        count_inc  = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_set  = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                state_d    = RUN;
                ifid_flush = 1'b1;
            end
            RUN: begin
                if (redirect_valid) begin
                    ifid_flush = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (tgt_misaligned) begin
                        fault_set = 1'b1;
                        state_d   = HALT;
                    end else
`endif
                    if (tgt_oob) begin
                        state_d = HALT;
                    end else begin
                        pc_d = tgt;
                    end
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    // Last word still registers; PC then parks on it.
                    count_inc = 1'b1;
                    if (seq_end) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_plus4[ADDR_W-1:0];
                    end
                end
            end
            HALT: begin
                ifid_flush = 1'b1;
            end
            default: begin
                state_d    = HALT;
                ifid_flush = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count <= '0;
        end else if (count_inc && (fetch_count != '1)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else if (fault_set) begin
            fault_q <= 1'b1;
        end
    end

    assign misalign_fault = fault_q;
`endif

    assign ifid_d = '{pc: pc_q, instr: imem.imem_instruction, valid: 1'b1};

    ifid_reg u_ifid (
        .clk     (clk),
        .reset_n (reset_n),
        .hold    (ifid_hold),
        .flush   (ifid_flush),
        .d       (ifid_d),
        .q       (ifid_q)
    );

    assign imem.imem_address = pc_q;
    assign ifid_pc           = ifid_q.pc;
    assign ifid_instr        = ifid_q.instr;
    assign ifid_valid        = ifid_q.valid;
    assign halted            = (state_q == HALT);

endmodule
